// File: rtl/hazard_pkg.sv
// hazard_pkg
//   Shared definitions for the hazard scoreboard: parameter defaults,
//   Tnew/Tuse encodings for the five-stage pipe, the mul/div op select
//   and a helper returning the busy length of a mul/div operation.
package hazard_pkg;

  localparam int NREG_DEF       = 32;
  localparam int AW_DEF         = 5;
  localparam int TW_DEF         = 3;
  localparam int MUL_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF = 10;
  localparam int CW_DEF         = 4;

  // Tuse: cycles from D until the operand is consumed.
  localparam logic [TW_DEF-1:0] TUSE_D = 3'd0;  // branch compare in D
  localparam logic [TW_DEF-1:0] TUSE_E = 3'd1;  // ALU operand in E
  localparam logic [TW_DEF-1:0] TUSE_M = 3'd2;  // store data in M

  // Tnew, measured while the producer sits in E.
  localparam logic [TW_DEF-1:0] TNEW_E = 3'd0;  // forwardable from E/M
  localparam logic [TW_DEF-1:0] TNEW_M = 3'd1;  // ALU result
  localparam logic [TW_DEF-1:0] TNEW_W = 3'd2;  // load result

  typedef enum logic {
    MD_MUL = 1'b0,
    MD_DIV = 1'b1
  } md_op_e;

  function automatic int md_cycles(input md_op_e op, input int mul_c, input int div_c);
    return (op == MD_DIV) ? div_c : mul_c;
  endfunction

endpackage

// File: rtl/md_busy_counter.sv
// md_busy_counter
//   Tracks how long the mul/div unit stays busy.
//   clk   : clock, rising edge
//   reset : asynchronous active-high clear
//   load  : an operation is issued this cycle (restarts the count)
//   div   : with load, 1 = divide, 0 = multiply
//   busy  : counter nonzero
module md_busy_counter
  import hazard_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int CW         = CW_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic div,
  output logic busy
);

  logic [CW-1:0] count_reg;
  md_op_e        op;

  assign op = div ? MD_DIV : MD_MUL;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= CW'(md_cycles(op, MUL_CYCLES, DIV_CYCLES));
    end else if (count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign busy = (count_reg != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Tnew/Tuse stall generator for a five-stage pipe. One down-counting
//   timer per architectural register holds the Tnew of its youngest
//   in-flight producer; a D-stage consumer stalls while that timer
//   exceeds its Tuse. A separate counter covers the mul/div unit.
//   clk, reset                    : clock / asynchronous active-high reset
//   D_valid                       : D holds a real instruction
//   D_rs, D_rt, D_tuse_rs/_rt     : sources read and their Tuse
//   D_A3, D_tnew                  : destination (0 = none) and its Tnew
//   D_md_use, D_md_start, D_md_div: mul/div usage / start / divide select
//   stall, stall_rs/_rt/_md       : combined and per-cause stall
//   md_busy                       : mul/div unit busy
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREG       = NREG_DEF,
  parameter int AW         = AW_DEF,
  parameter int TW         = TW_DEF,
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int CW         = CW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          D_valid,
  input  logic [AW-1:0] D_rs,
  input  logic [AW-1:0] D_rt,
  input  logic [TW-1:0] D_tuse_rs,
  input  logic [TW-1:0] D_tuse_rt,
  input  logic [AW-1:0] D_A3,
  input  logic [TW-1:0] D_tnew,
  input  logic          D_md_use,
  input  logic          D_md_start,
  input  logic          D_md_div,
  output logic          stall,
  output logic          stall_rs,
  output logic          stall_rt,
  output logic          stall_md,
  output logic          md_busy
);

  // Address space may exceed NREG; unused slots and $0 read as zero.
  localparam int NSLOT = 1 << AW;

  logic [NSLOT*TW-1:0] timer_flat;
  logic [TW-1:0]       rs_timer;
  logic [TW-1:0]       rt_timer;
  logic                issue;

  assign issue = D_valid & ~stall;

  genvar gi;
  generate
    for (gi = 0; gi < NSLOT; gi++) begin : g_timer
      if (gi == 0 || gi >= NREG) begin : g_zero
        assign timer_flat[gi*TW +: TW] = '0;
      end else begin : g_track
        logic [TW-1:0] timer_reg;
        // A newly issued producer overrides the decrement of an older one.
        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            timer_reg <= '0;
          end else if (issue && (D_A3 == AW'(gi))) begin
            timer_reg <= D_tnew;
          end else if (timer_reg != '0) begin
            timer_reg <= timer_reg - 1'b1;
          end
        end
        assign timer_flat[gi*TW +: TW] = timer_reg;
      end
    end
  endgenerate

  assign rs_timer = timer_flat[int'(D_rs)*TW +: TW];
  assign rt_timer = timer_flat[int'(D_rt)*TW +: TW];

  assign stall_rs = D_valid & (D_rs != '0) & (rs_timer > D_tuse_rs);
  assign stall_rt = D_valid & (D_rt != '0) & (rt_timer > D_tuse_rt);
  assign stall_md = D_valid & D_md_use & md_busy;
  assign stall    = stall_rs | stall_rt | stall_md;

  // Only an issued start loads; a start arriving while busy stalls on
  // stall_md and therefore cannot restart the count.
  md_busy_counter #(
    .MUL_CYCLES(MUL_CYCLES),
    .DIV_CYCLES(DIV_CYCLES),
    .CW        (CW)
  ) u_md_busy_counter (
    .clk  (clk),
    .reset(reset),
    .load (issue & D_md_start),
    .div  (D_md_div),
    .busy (md_busy)
  );

endmodule
